// File: rtl/mat_mult_nd_if.sv
// Operand, result and handshake bus of the NxN fixed-point matrix multiplier.
// The requester drives the master side; mat_mult_nd uses the slave side.
interface mat_mult_nd_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic                       start;
    logic                       mult_vec;
    logic                       acc;
    logic [N-1:0][N-1:0][W-1:0] m;
    logic [N-1:0][N-1:0][W-1:0] v;
    logic [N-1:0][N-1:0][W-1:0] o;
    logic                       busy;
    logic                       done;
    logic                       ovf;

    modport master (output start, mult_vec, acc, m, v, input o, busy, done, ovf);
    modport slave  (input start, mult_vec, acc, m, v, output o, busy, done, ovf);
endinterface

// File: rtl/mat_mult_nd.sv
// Signed fixed-point NxN matrix (or matrix*vector) multiplier with one serial MAC.
// Define MAT_MULT_SAT_EN to saturate on narrowing instead of wrapping.
module mat_mult_nd #(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input logic          clock,
    input logic          reset,
    mat_mult_nd_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int PW = 2 * W;
    localparam int AW = PW + CW;
    localparam int SW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, next_state;

    logic [N-1:0][N-1:0][W-1:0] m_s, v_s, o_q;
    logic                       vec_mode, acc_mode;
    logic [CW-1:0]              r_idx, c_idx, k_idx, c_last;
    logic                       accept, issue_last, done_c;

    logic                       a_valid;
    logic signed [W-1:0]        a_q, b_q;
    logic [CW-1:0]              a_r, a_c, a_k;
    logic                       p_valid;
    logic signed [PW-1:0]       p_q;
    logic [CW-1:0]              p_r, p_c, p_k;

    logic signed [AW-1:0]       acc_q, acc_base, p_ext, acc_next, shifted;
    logic [SW-1:0]              s_sum;
    logic [W-1:0]               o_old, res;
    logic                       ovf_det, busy_q, ovf_q;

    assign accept     = bus.start && (state == IDLE || state == DONE);
    assign c_last     = vec_mode ? '0 : LAST;
    assign issue_last = (state == RUN) && (r_idx == LAST) && (c_idx == c_last) && (k_idx == LAST);

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        done_c     = 1'b0;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (issue_last) next_state = DRAIN;
            DRAIN:   if (!a_valid && !p_valid) next_state = DONE;
            DONE: begin
                done_c     = 1'b1;
                next_state = accept ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Final stage of an element: rescale, optionally add the old result, then narrow.
    assign p_ext    = {{CW{p_q[PW-1]}}, p_q};
    assign acc_base = (p_k == '0) ? '0 : acc_q;
    assign acc_next = acc_base + p_ext;
    assign shifted  = acc_next >>> FRAC;
    assign o_old    = o_q[p_r][p_c];
    assign s_sum    = {shifted[AW-1], shifted} + (acc_mode ? {{(SW-W){o_old[W-1]}}, o_old} : '0);
    assign ovf_det  = !((&s_sum[SW-1:W-1]) || !(|s_sum[SW-1:W-1]));

`ifdef MAT_MULT_SAT_EN
    assign res = !ovf_det      ? s_sum[W-1:0] :
                 s_sum[SW-1]   ? {1'b1, {(W-1){1'b0}}} :
                                 {1'b0, {(W-1){1'b1}}};
`else
    assign res = s_sum[W-1:0];
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            m_s      <= '0;
            v_s      <= '0;
            o_q      <= '0;
            vec_mode <= 1'b0;
            acc_mode <= 1'b0;
            r_idx    <= '0;
            c_idx    <= '0;
            k_idx    <= '0;
            a_valid  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            a_r      <= '0;
            a_c      <= '0;
            a_k      <= '0;
            p_valid  <= 1'b0;
            p_q      <= '0;
            p_r      <= '0;
            p_c      <= '0;
            p_k      <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // Issue order: row outer, column middle, k inner.
            if (accept) begin
                m_s      <= bus.m;
                v_s      <= bus.v;
                vec_mode <= bus.mult_vec;
                acc_mode <= bus.acc;
                r_idx    <= '0;
                c_idx    <= '0;
                k_idx    <= '0;
            end else if (state == RUN) begin
                if (k_idx == LAST) begin
                    k_idx <= '0;
                    if (c_idx == c_last) begin
                        c_idx <= '0;
                        r_idx <= r_idx + CW'(1);
                    end else begin
                        c_idx <= c_idx + CW'(1);
                    end
                end else begin
                    k_idx <= k_idx + CW'(1);
                end
            end

            a_valid <= (state == RUN);
            a_q     <= m_s[r_idx][k_idx];
            b_q     <= v_s[k_idx][c_idx];
            a_r     <= r_idx;
            a_c     <= c_idx;
            a_k     <= k_idx;

            p_valid <= a_valid;
            p_q     <= a_q * b_q;
            p_r     <= a_r;
            p_c     <= a_c;
            p_k     <= a_k;

            if (p_valid) begin
                acc_q <= acc_next;
                if (p_k == LAST) o_q[p_r][p_c] <= res;
            end

            if (accept)                               ovf_q <= 1'b0;
            else if (p_valid && p_k == LAST && ovf_det) ovf_q <= 1'b1;

            // Registered so busy rises one cycle after the start edge and falls as done rises.
            busy_q <= (state == RUN || state == DRAIN) && (next_state != DONE);
        end
    end

    assign bus.o    = o_q;
    assign bus.busy = busy_q;
    assign bus.done = done_c;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_mat_mult_nd.sv
// Directed bench for mat_mult_nd (N=4, W=32, Q16.16); expected values computed by hand.
// Compile with MAT_MULT_SAT_EN to match a saturating build.
module tb_mat_mult_nd;
    localparam int N    = 4;
    localparam int W    = 32;
    localparam int FRAC = 16;

    logic clock;
    logic reset;

    mat_mult_nd_if #(.N(N), .W(W)) bus ();

    mat_mult_nd #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [N-1:0][N-1:0][W-1:0] m_tb, v_tb, exp_o, zero_o;
    int  done_at, busy_cnt;
    bit  overlap, done_seen, busy_seen;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_matrix(input string tag, input logic [N-1:0][N-1:0][W-1:0] want);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check_output($sformatf("%s o[%0d][%0d]", tag, r, c), 64'(bus.o[r][c]), 64'(want[r][c]));
    endtask

    // Pulses start (sampled at the next edge) and watches until done or a 200-cycle budget.
    // t counts edges after the start-sampling edge; poke_at re-asserts start while busy;
    // chain leaves start high in the done cycle so the next op is back-to-back.
    task automatic apply_stimulus(input bit vec, input bit accm, input int poke_at, input bit chain,
                                  output int done_at_o, output int busy_o, output bit overlap_o);
        bus.m        = m_tb;
        bus.v        = v_tb;
        bus.mult_vec = vec;
        bus.acc      = accm;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        done_at_o = -1;
        busy_o    = 0;
        overlap_o = 1'b0;
        for (int t = 0; t <= 200 && done_at_o < 0; t++) begin
            if (t > 0) begin
                @(posedge clock); #1;
            end
            if (bus.busy) busy_o++;
            if (bus.busy && bus.done) overlap_o = 1'b1;
            bus.start = (t == poke_at);
            if (bus.done) begin
                done_at_o = t;
                if (chain) bus.start = 1'b1;
            end
        end
    endtask

    function automatic logic [N-1:0][N-1:0][W-1:0] diag(input logic [W-1:0] d);
        logic [N-1:0][N-1:0][W-1:0] x;
        x = '0;
        for (int i = 0; i < N; i++) x[i][i] = d;
        return x;
    endfunction

    initial begin
        zero_o       = '0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.mult_vec = 1'b0;
        bus.acc      = 1'b0;
        bus.m        = '0;
        bus.v        = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_output("reset busy", 64'(bus.busy), 64'd0);
        check_output("reset done", 64'(bus.done), 64'd0);
        check_output("reset ovf", 64'(bus.ovf), 64'd0);
        check_matrix("reset", zero_o);
        reset = 1'b1;
        @(posedge clock); #1;

        // Identity times random V, matrix mode: O == V
        $display("[TB] identity matrix op");
        m_tb = diag(32'h0001_0000);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) v_tb[r][c] = $urandom;
        exp_o = v_tb;
        apply_stimulus(1'b0, 1'b0, -1, 1'b0, done_at, busy_cnt, overlap);
        check_output("ident done_at", 64'(done_at), 64'd67);
        check_output("ident busy_cycles", 64'(busy_cnt), 64'd66);
        check_output("ident busy_done_overlap", 64'(overlap), 64'd0);
        check_output("ident ovf", 64'(bus.ovf), 64'd0);
        check_matrix("ident", exp_o);
        @(posedge clock); #1;
        check_output("ident done_single_cycle", 64'(bus.done), 64'd0);
        check_output("ident busy_after", 64'(bus.busy), 64'd0);

        // Vector mode, M = 2.0*I; columns 1..3 of V hold junk that must not leak into O
        $display("[TB] vector mode op");
        m_tb = diag(32'h0002_0000);
        for (int r = 0; r < N; r++) begin
            v_tb[r][0] = W'((r + 1) * 32'h0001_0000);
            for (int c = 1; c < N; c++) v_tb[r][c] = 32'hDEAD_0000 + W'(r * N + c);
        end
        for (int r = 0; r < N; r++) exp_o[r][0] = W'((r + 1) * 32'h0002_0000);
        apply_stimulus(1'b1, 1'b0, -1, 1'b0, done_at, busy_cnt, overlap);
        check_output("vec done_at", 64'(done_at), 64'd19);
        check_output("vec busy_cycles", 64'(busy_cnt), 64'd18);
        check_matrix("vec", exp_o);
        @(posedge clock); #1;

        // Accumulate, with an ignored start at +10 and a chained start in the done cycle
        $display("[TB] accumulate with mid-op and back-to-back starts");
        for (int r = 0; r < N; r++) exp_o[r][0] = W'((r + 1) * 32'h0004_0000);
        apply_stimulus(1'b1, 1'b1, 10, 1'b1, done_at, busy_cnt, overlap);
        check_output("acc1 done_at", 64'(done_at), 64'd19);
        check_output("acc1 busy_done_overlap", 64'(overlap), 64'd0);
        check_matrix("acc1", exp_o);
        for (int r = 0; r < N; r++) exp_o[r][0] = W'((r + 1) * 32'h0006_0000);
        apply_stimulus(1'b1, 1'b1, -1, 1'b0, done_at, busy_cnt, overlap);
        check_output("acc2 done_at", 64'(done_at), 64'd19);
        check_output("acc2 busy_cycles", 64'(busy_cnt), 64'd18);
        check_matrix("acc2", exp_o);
        @(posedge clock); #1;
        check_output("acc2 done_single_cycle", 64'(bus.done), 64'd0);

        // Narrowing overflow: 32767.0 * 2.0 does not fit in Q16.16
        $display("[TB] overflow op");
        m_tb = '0;
        m_tb[0][0] = 32'h7FFF_0000;
        v_tb = '0;
        v_tb[0][0] = 32'h0002_0000;
`ifdef MAT_MULT_SAT_EN
        exp_o[0][0] = 32'h7FFF_FFFF;
`else
        exp_o[0][0] = 32'hFFFE_0000;
`endif
        for (int r = 1; r < N; r++) exp_o[r][0] = '0;
        apply_stimulus(1'b1, 1'b0, -1, 1'b0, done_at, busy_cnt, overlap);
        check_output("ovf done_at", 64'(done_at), 64'd19);
        check_output("ovf flag", 64'(bus.ovf), 64'd1);
        check_matrix("ovf", exp_o);
        @(posedge clock); #1;
        check_output("ovf sticky", 64'(bus.ovf), 64'd1);

        // Reset in the middle of a matrix op, then a clean op afterwards
        $display("[TB] reset during matrix op");
        m_tb = diag(32'h0001_0000);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) v_tb[r][c] = $urandom;
        bus.m        = m_tb;
        bus.v        = v_tb;
        bus.mult_vec = 1'b0;
        bus.acc      = 1'b0;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check_output("ovf cleared on start", 64'(bus.ovf), 64'd0);
        repeat (29) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_output("midreset busy", 64'(bus.busy), 64'd0);
        check_output("midreset done", 64'(bus.done), 64'd0);
        check_matrix("midreset", zero_o);
        reset = 1'b1;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (80) begin
            @(posedge clock); #1;
            if (bus.done) done_seen = 1'b1;
            if (bus.busy) busy_seen = 1'b1;
        end
        check_output("postreset done_seen", 64'(done_seen), 64'd0);
        check_output("postreset busy_seen", 64'(busy_seen), 64'd0);
        check_matrix("postreset", zero_o);
        exp_o = v_tb;
        apply_stimulus(1'b0, 1'b0, -1, 1'b0, done_at, busy_cnt, overlap);
        check_output("recover done_at", 64'(done_at), 64'd67);
        check_output("recover busy_cycles", 64'(busy_cnt), 64'd66);
        check_matrix("recover", exp_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
